// File: rtl/compress_encode_ctrl_pkg.sv
// Shared constants and FSM encoding for the compress/encode sequencer.
package compress_encode_ctrl_pkg;

  localparam int CE_N_PAIRS  = 128;
  localparam int CE_AW       = 7;
  localparam int CE_OAW      = 7;
  localparam int CE_WD_LIMIT = 64;
  localparam int CE_WP_DD4   = 32;
  localparam int CE_WP_DD10  = 80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } ce_state_e;

endpackage

// File: rtl/compress_encode_ctrl_if.sv
// Handshake bundle between the sequencer, coefficient RAM, datapath and output sink.
interface compress_encode_ctrl_if
  import compress_encode_ctrl_pkg::*;
#(
  parameter int AW  = CE_AW,
  parameter int OAW = CE_OAW
);
  logic           start;
  logic           dd_sel;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic           dp_set;
  logic           dp_reset;
  logic           dp_readin;
  logic           dp_readout_ok;
  logic           out_ready;
  logic           out_we;
  logic [OAW-1:0] out_addr;
  logic           err;

  modport slave (
    input  start, dd_sel, dp_readout_ok, out_ready,
    output busy, done, rd_en, rd_addr, dp_set, dp_reset, dp_readin, out_we, out_addr, err
  );

  modport master (
    output start, dd_sel, dp_readout_ok, out_ready,
    input  busy, done, rd_en, rd_addr, dp_set, dp_reset, dp_readin, out_we, out_addr, err
  );
endinterface

// File: rtl/compress_encode_ctrl.sv
// Sequencer for one compress_encode datapath: streams coefficient pairs in, collects word pairs out.
// Optional drain watchdog enabled by defining CE_WATCHDOG_EN.
module compress_encode_ctrl
  import compress_encode_ctrl_pkg::*;
#(
  parameter int N_PAIRS = CE_N_PAIRS,
  parameter int AW      = CE_AW,
  parameter int OAW     = CE_OAW
) (
  input logic                  clk,
  input logic                  reset,
  compress_encode_ctrl_if.slave bus
);

  localparam logic [AW-1:0]  LAST_PAIR = AW'(N_PAIRS - 1);
  localparam logic [OAW-1:0] WP4       = OAW'(CE_WP_DD4);
  localparam logic [OAW-1:0] WP10      = OAW'(CE_WP_DD10);

  ce_state_e      state_q, state_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic [OAW-1:0] wcnt_q, wcnt_d;
  logic           dd_q, dd_d;
  logic [OAW-1:0] wp_target;
  logic           dp_set, out_we;
  logic           done, rd_en, dp_reset, dp_readin;
  logic [AW-1:0]  rd_addr;

`ifdef CE_WATCHDOG_EN
  localparam int              WD_W    = $clog2(CE_WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(CE_WD_LIMIT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Sink backpressure freezes the whole datapath, so the clock enable is out_ready itself.
  assign dp_set    = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) & bus.out_ready;
  assign out_we    = bus.dp_readout_ok & dp_set;
  assign wp_target = dd_q ? WP10 : WP4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      wcnt_q    <= '0;
      dd_q      <= 1'b0;
`ifdef CE_WATCHDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wcnt_q    <= wcnt_d;
      dd_q      <= dd_d;
`ifdef CE_WATCHDOG_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wcnt_d    = wcnt_q;
    dd_d      = dd_q;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_addr_q;
    dp_reset  = 1'b0;
    dp_readin = 1'b0;
`ifdef CE_WATCHDOG_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_CLR;
          dd_d      = bus.dd_sel;
          rd_addr_d = '0;
          wcnt_d    = '0;
`ifdef CE_WATCHDOG_EN
          wd_d      = '0;
`endif
        end
      end
      ST_CLR: begin
        // Pre-fetch pair 0 so it is on the RAM output in the first ISSUE cycle.
        dp_reset = 1'b1;
        rd_en    = 1'b1;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (dp_set) begin
          dp_readin = 1'b1;
          if (rd_addr_q == LAST_PAIR) begin
            state_d = ST_DRAIN;
          end else begin
            rd_en     = 1'b1;
            rd_addr   = rd_addr_q + 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if ((wcnt_q == wp_target) || (out_we && ((wcnt_q + 1'b1) == wp_target)))
          state_d = ST_DONE;
`ifdef CE_WATCHDOG_EN
        if (out_we) begin
          wd_d = '0;
        end else if (dp_set) begin
          if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
`endif
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_we) wcnt_d = wcnt_q + 1'b1;
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.dp_set    = dp_set;
  assign bus.dp_reset  = dp_reset;
  assign bus.dp_readin = dp_readin;
  assign bus.out_we    = out_we;
  assign bus.out_addr  = wcnt_q;
`ifdef CE_WATCHDOG_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_compress_encode_ctrl.sv
// Randomized bench: RAM + datapath behavioural models around the sequencer, bit-stream reference.
module tb_compress_encode_ctrl;
  import compress_encode_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  compress_encode_ctrl_if #(.AW(CE_AW), .OAW(CE_OAW)) bus();

  compress_encode_ctrl dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0]      coef [256];
  logic [11:0]      ram_c0 = '0;
  logic [11:0]      ram_c1 = '0;
  bit               cur_dd = 1'b0;
  bit               kill_ok = 1'b0;
  logic [9:0]       line_v = '0;
  logic [9:0][31:0] line_d = '0;
  logic [63:0]      acc_q = '0;
  logic [63:0]      acc_n;
  int               nb_q = 0;
  int               nb_n;
  logic             tok_v;
  logic [31:0]      tok_d;
  logic [21:0]      ovec;
  logic [31:0]      ref_q[$];
  logic [6:0]       got_a[$];
  logic [31:0]      got_d[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] comp(input logic [11:0] c, input bit dd);
    return dd ? c[11:2] : {6'b0, c[11:8]};
  endfunction

  // Coefficient RAM, one-cycle read latency, output holds without rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      ram_c0 <= coef[2 * int'(bus.rd_addr)];
      ram_c1 <= coef[2 * int'(bus.rd_addr) + 1];
    end
  end

  // Datapath stand-in: packs compressed coefficients LSB-first into 32-bit word pairs,
  // then delays each word pair by 10 enabled cycles.
  always_comb begin
    acc_n = acc_q;
    nb_n  = nb_q;
    tok_v = 1'b0;
    tok_d = '0;
    if (bus.dp_readin) begin
      acc_n = acc_n | (64'(comp(ram_c0, cur_dd)) << nb_n);
      nb_n  = nb_n + (cur_dd ? 10 : 4);
      acc_n = acc_n | (64'(comp(ram_c1, cur_dd)) << nb_n);
      nb_n  = nb_n + (cur_dd ? 10 : 4);
      if (nb_n >= 32) begin
        tok_v = 1'b1;
        tok_d = acc_n[31:0];
        acc_n = acc_n >> 32;
        nb_n  = nb_n - 32;
      end
    end
  end

  always @(posedge clk) begin
    if (bus.dp_reset) begin
      line_v <= '0;
      acc_q  <= '0;
      nb_q   <= 0;
    end else if (bus.dp_set) begin
      line_v <= {line_v[8:0], tok_v};
      line_d <= {line_d[8:0], tok_d};
      acc_q  <= acc_n;
      nb_q   <= nb_n;
    end
  end

  assign bus.dp_readout_ok = line_v[9] & ~kill_ok;
  assign ovec = {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.dp_set, bus.dp_reset,
                 bus.dp_readin, bus.out_we, bus.out_addr, bus.err};

  task automatic build_ref(input bit dd);
    bit          s[$];
    logic [9:0]  c;
    logic [31:0] w;
    int          d;
    d = dd ? 10 : 4;
    ref_q.delete();
    for (int j = 0; j < 256; j++) begin
      c = comp(coef[j], dd);
      for (int b = 0; b < d; b++) s.push_back(c[b]);
    end
    for (int k = 0; k < s.size() / 32; k++) begin
      w = '0;
      for (int b = 0; b < 32; b++) w[b] = s[32 * k + b];
      ref_q.push_back(w);
    end
  endtask

  task automatic run_poly(input string nm, input bit dd, input int pct, input bit disturb,
                          input int abort_at, input bit kill);
    int cyc = 0, nrd = 0, nwe = 0, ndone = 0, set_since = 0, first_we_set = 0;
    int last_we_cyc = -10, done_cyc = 0, nset_drain = 0, tgt;
    bit seen_rd = 0, seen_we = 0, fin = 0, stalled = 0, chk_stall = 0, err_at_done = 0;

    build_ref(dd);
    got_a.delete();
    got_d.delete();
    tgt = dd ? 80 : 32;
    kill_ok = kill;

    @(negedge clk);
    bus.start = 1'b1; bus.dd_sel = dd; cur_dd = dd; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk({nm, "_clr"}, {bus.busy, bus.dp_reset, bus.rd_en, bus.dp_set, bus.rd_addr},
        {1'b1, 1'b1, 1'b1, 1'b0, 7'd0});

    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = ($urandom_range(0, 99) < pct);
      if (pct < 100 && nrd == 127 && !stalled && bus.busy) begin
        bus.out_ready = 1'b0;
        stalled = 1;
        chk_stall = 1;
      end
      if (disturb) begin
        bus.start = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) bus.dd_sel = ~bus.dd_sel;
      end
      #1;
      if (chk_stall) begin
        chk({nm, "_last_stall"}, {bus.rd_addr, bus.rd_en, bus.dp_readin, bus.dp_set},
            {7'd127, 3'b000});
        chk_stall = 0;
      end
      if (bus.dp_readin) begin
        seen_rd = 1;
        nrd++;
      end
      if (bus.out_we) begin
        if (!seen_we) first_we_set = set_since;
        seen_we = 1;
        got_a.push_back(bus.out_addr);
        got_d.push_back(line_d[9]);
        nwe++;
        last_we_cyc = cyc;
      end
      if (seen_rd && bus.dp_set) set_since++;
      if (nrd == 128 && bus.dp_set && !bus.dp_readin) nset_drain++;
      if (abort_at >= 0 && nrd == abort_at) begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        chk({nm, "_reset_outputs"}, ovec, 22'h0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (bus.done) begin
        ndone++;
        done_cyc = cyc;
        err_at_done = bus.err;
        bus.start = 1'b0;
        fin = 1;
      end
    end
    bus.start = 1'b0;
    chk({nm, "_finished"}, fin, 1);

    @(negedge clk);
    #1;
    chk({nm, "_busy_after"}, {bus.busy, bus.done}, 2'b00);
    chk({nm, "_ndone"}, ndone, 1);
    chk({nm, "_nreadin"}, nrd, 128);
    if (kill) begin
      chk({nm, "_wd_cycles"}, nset_drain, 64);
      chk({nm, "_err_at_done"}, err_at_done, 1);
      chk({nm, "_err_sticky"}, bus.err, 1);
      chk({nm, "_nwe"}, nwe, 0);
    end else begin
      chk({nm, "_nwe"}, nwe, tgt);
      chk({nm, "_out_addr_end"}, bus.out_addr, tgt);
      chk({nm, "_done_after_last_we"}, done_cyc, last_we_cyc + 1);
      chk({nm, "_latency_ok"}, first_we_set >= 10, 1);
      chk({nm, "_err"}, err_at_done, 0);
      for (int i = 0; i < nwe && i < ref_q.size(); i++) begin
        chk($sformatf("%s_addr%0d", nm, i), got_a[i], i);
        chk($sformatf("%s_word%0d", nm, i), got_d[i], ref_q[i]);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dd_sel = 1'b0;
    bus.out_ready = 1'b0;
    for (int j = 0; j < 256; j++) coef[j] = 12'($urandom);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", ovec, 22'h0);
    bus.start = 1'b1;
    @(negedge clk);
    #1;
    chk("start_in_reset_ignored", ovec, 22'h0);
    bus.start = 1'b0;
    rst_n = 1'b1;

    run_poly("t1_dd4", 1'b0, 100, 1'b0, -1, 1'b0);
    run_poly("t2_dd10", 1'b1, 100, 1'b0, -1, 1'b0);
    run_poly("t3_dd4_bp", 1'b0, 50, 1'b0, -1, 1'b0);
    run_poly("t4_disturb", 1'b0, 60, 1'b1, -1, 1'b0);
    run_poly("t5_abort", 1'b1, 70, 1'b0, 60, 1'b0);
    run_poly("t5_rerun", 1'b1, 100, 1'b0, -1, 1'b0);
    run_poly("t5_rerun_bp", 1'b1, 40, 1'b0, -1, 1'b0);
`ifdef CE_WATCHDOG_EN
    run_poly("t6_wd", 1'b0, 70, 1'b0, -1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
